muxn_rr: RTL and testbench

MUXN_RR -- requirements
Module: muxn_rr

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/muxn_rr.sv | 88 ++++++++
 tb/tb_muxn_rr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 registered channel multiplexer.
package mux_pkg;

  // Arbitration modes selectable through the MODE parameter.
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection for muxn_rr: fixed index select or round-robin search.
// Purely combinational; grant is one-hot or zero and only covers requesting
// channels.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int MODE = MODE_RR,
  localparam int IW   = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] sel,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  // Requests rotated so that bit 0 is the channel at ptr.
  logic [2*N-1:0] rot;
  int             first;
  int             win;
  logic           found;

  // Pick the winning channel and drive its one-hot grant bit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // this block can never infer a latch.
    grant = '0;
    rot   = '0;
    first = 0;
    win   = 0;
    found = 1'b0;
    if (MODE == MODE_FIXED) begin
      // Out-of-range or idle sel grants nothing.
      for (int i = 0; i < N; i++) begin
        if ((int'(sel) == i) && req[i]) grant[i] = 1'b1;
      end
    end else begin
      // Doubling the vector makes the wrap from N-1 to 0 a plain shift.
      rot   = {req, req} >> ptr;
      found = |rot[N-1:0];
      // Scan downwards so the lowest set bit (closest to ptr) wins.
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) first = k;
      end
      win = (int'(ptr) + first) % N;
      if (found) begin
        for (int i = 0; i < N; i++) begin
          if (i == win) grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/muxn_rr.sv
// N-channel valid/ready multiplexer with a one-entry registered output.
// Arbitration lives in rr_arbiter; this module owns the datapath, the output
// register and the round-robin pointer.
module muxn_rr
  import mux_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int N    = 4,
  parameter  int MODE = MODE_RR,
  localparam int IW   = idx_w(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [IW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0]  grant;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          can_load;
  logic          accept;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req   (in_valid),
    .sel   (sel),
    .ptr   (ptr),
    .grant (grant)
  );

  // The output slot is free when empty or being drained this cycle; reset
  // also masks in_ready so nothing is offered while the block is held.
  assign can_load = !out_valid || out_ready;
  assign in_ready = (rst_n && can_load) ? grant : '0;
  assign accept   = |in_ready;

  // Encode the accepted channel's index and select its word.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_ready[i]) begin
        gnt_idx  = IW'(i);
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  // Pointer moves to the channel after the winner, wrapping at N-1.
  assign ptr_nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

  // Output register: load on accept, clear valid on a drain with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset as well, so out_data reads as zero
      // while the block is held in reset rather than showing a stale word.
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      out_valid <= 1'b1;
      out_data  <= gnt_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances only on an accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_muxn_rr.sv
// Bench for muxn_rr: one fixed-select and one round-robin instance, directed
// vectors, and a scoreboard monitor that checks every delivered word.
module tb_muxn_rr;
  import mux_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*W-1:0] f_in_data, r_in_data;
  logic [N-1:0]   f_in_valid, r_in_valid, f_in_ready, r_in_ready;
  logic [IW-1:0]  f_sel, r_sel;
  logic [W-1:0]   f_out_data, r_out_data;
  logic           f_out_valid, r_out_valid, f_out_ready, r_out_ready;

  muxn_rr #(.W(W), .N(N), .MODE(MODE_FIXED)) dut_fix (
    .clk(clk), .rst_n(rst_n), .in_data(f_in_data), .in_valid(f_in_valid),
    .in_ready(f_in_ready), .sel(f_sel), .out_data(f_out_data),
    .out_valid(f_out_valid), .out_ready(f_out_ready)
  );

  muxn_rr #(.W(W), .N(N), .MODE(MODE_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(r_in_data), .in_valid(r_in_valid),
    .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_f[$];
  logic [W-1:0] exp_r[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard monitor: on every delivered word, pop the expected value.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (f_out_valid === 1'b1 && f_out_ready === 1'b1) begin
        if (exp_f.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_fix_unexpected: got %h expected no word", f_out_data);
        end else begin
          check("sb_fix_data", 32'(f_out_data), 32'(exp_f.pop_front()));
        end
      end
      if (r_out_valid === 1'b1 && r_out_ready === 1'b1) begin
        if (exp_r.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_rr_unexpected: got %h expected no word", r_out_data);
        end else begin
          check("sb_rr_data", 32'(r_out_data), 32'(exp_r.pop_front()));
        end
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [N-1:0] rr_exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [W-1:0] rr_exp_d [6] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hA001, 16'hB002};

  initial begin
    rst_n = 1'b1;
    f_in_data = {16'hA5C3, 16'hBEEF, 16'h1357, 16'h8001};
    r_in_data = {16'hD004, 16'hC003, 16'hB002, 16'hA001};
    f_in_valid = '0; r_in_valid = '0;
    f_sel = '0; r_sel = '0;
    f_out_ready = 1'b0; r_out_ready = 1'b0;

    // Reset forces outputs low even with every channel requesting.
    #1 rst_n = 1'b0;
    f_in_valid = 4'hF;
    r_in_valid = 4'hF;
    #2;
    check("rst_fix_out_valid", 32'(f_out_valid), 0);
    check("rst_fix_in_ready", 32'(f_in_ready), 0);
    check("rst_rr_out_valid", 32'(r_out_valid), 0);
    check("rst_rr_out_data", 32'(r_out_data), 0);
    check("rst_rr_in_ready", 32'(r_in_ready), 0);
    cyc();
    rst_n = 1'b1;
    f_in_valid = '0;
    r_in_valid = '0;

    // Fixed select: sel=2 with channel 2 valid.
    f_sel = 2'd2; f_in_valid = 4'b0100; f_out_ready = 1'b1;
    settle();
    check("fix_sel2_in_ready", 32'(f_in_ready), 32'(4'b0100));
    exp_f.push_back(16'hBEEF);
    cyc();
    // sel=2 but channel 2 idle: nothing accepted.
    f_in_valid = 4'b1011;
    settle();
    check("fix_sel2_out_valid", 32'(f_out_valid), 1);
    check("fix_sel2_out_data", 32'(f_out_data), 32'(16'hBEEF));
    check("fix_sel_idle_in_ready", 32'(f_in_ready), 0);
    cyc();
    f_sel = 2'd3;
    settle();
    check("fix_drain_out_valid", 32'(f_out_valid), 0);
    check("fix_sel3_in_ready", 32'(f_in_ready), 32'(4'b1000));
    exp_f.push_back(16'hA5C3);
    cyc();
    // Drain and accept in the same cycle.
    f_sel = 2'd0;
    settle();
    check("fix_sel3_out_data", 32'(f_out_data), 32'(16'hA5C3));
    check("fix_b2b_in_ready", 32'(f_in_ready), 32'(4'b0001));
    exp_f.push_back(16'h8001);
    cyc();
    f_in_valid = '0;
    settle();
    check("fix_msb_out_data", 32'(f_out_data), 32'(16'h8001));
    check("fix_idle_in_ready", 32'(f_in_ready), 0);
    cyc();
    settle();
    check("fix_final_out_valid", 32'(f_out_valid), 0);
    check("fix_hold_out_data", 32'(f_out_data), 32'(16'h8001));
    f_out_ready = 1'b0;
    cyc();

    // Round-robin: all channels valid for 6 cycles.
    r_out_ready = 1'b1;
    r_in_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("rr_rotate_in_ready", 32'(r_in_ready), 32'(rr_exp_g[c]));
      if (c > 0) check("rr_rotate_out_valid", 32'(r_out_valid), 1);
      exp_r.push_back(rr_exp_d[c]);
      cyc();
    end
    r_in_valid = '0;
    settle();
    check("rr_rotate_last_valid", 32'(r_out_valid), 1);
    check("rr_rotate_last_data", 32'(r_out_data), 32'(16'hB002));
    check("rr_idle_in_ready", 32'(r_in_ready), 0);
    cyc();

    // Backpressure: pointer is 2, load 16'h1234 then stall for 3 cycles.
    r_in_data[2*W +: W] = 16'h1234;
    r_in_valid = 4'b0100;
    settle();
    check("rr_load_in_ready", 32'(r_in_ready), 32'(4'b0100));
    exp_r.push_back(16'h1234);
    cyc();
    r_out_ready = 1'b0;
    r_in_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("rr_stall_in_ready", 32'(r_in_ready), 0);
      check("rr_stall_out_data", 32'(r_out_data), 32'(16'h1234));
      check("rr_stall_out_valid", 32'(r_out_valid), 1);
      cyc();
    end
    r_out_ready = 1'b1;
    r_in_valid = 4'b0100;
    r_in_data[2*W +: W] = 16'h5678;
    settle();
    check("rr_release_in_ready", 32'(r_in_ready), 32'(4'b0100));
    exp_r.push_back(16'h5678);
    cyc();

    // Pointer is 3, only channels 0 and 1 valid: wrap to 0 then 1.
    r_in_valid = 4'b0011;
    settle();
    check("rr_release_out_data", 32'(r_out_data), 32'(16'h5678));
    check("rr_wrap_grant0", 32'(r_in_ready), 32'(4'b0001));
    exp_r.push_back(16'hA001);
    cyc();
    settle();
    check("rr_wrap_grant1", 32'(r_in_ready), 32'(4'b0010));
    exp_r.push_back(16'hB002);
    cyc();
    r_in_valid = '0;
    settle();
    check("rr_wrap_idle_in_ready", 32'(r_in_ready), 0);
    cyc();

    // Pointer is 2: accept channel 2 (ptr -> 3) and stall it, then reset.
    r_in_data[2*W +: W] = 16'hC003;
    r_in_valid = 4'b0100;
    settle();
    check("rr_pre_reset_grant", 32'(r_in_ready), 32'(4'b0100));
    cyc();
    r_out_ready = 1'b0;
    r_in_valid = 4'b1100;
    settle();
    check("rr_pre_reset_out_valid", 32'(r_out_valid), 1);
    check("rr_pre_reset_out_data", 32'(r_out_data), 32'(16'hC003));
    rst_n = 1'b0;
    #1;
    check("rr_async_rst_out_valid", 32'(r_out_valid), 0);
    check("rr_async_rst_out_data", 32'(r_out_data), 0);
    check("rr_async_rst_in_ready", 32'(r_in_ready), 0);
    cyc();
    rst_n = 1'b1;
    r_out_ready = 1'b1;
    settle();
    check("rr_post_reset_grant", 32'(r_in_ready), 32'(4'b0100));
    exp_r.push_back(16'hC003);
    cyc();
    settle();
    check("rr_post_reset_out_data", 32'(r_out_data), 32'(16'hC003));
    check("rr_post_reset_next_grant", 32'(r_in_ready), 32'(4'b1000));
    exp_r.push_back(16'hD004);
    cyc();
    r_in_valid = '0;
    settle();
    check("rr_last_out_data", 32'(r_out_data), 32'(16'hD004));
    cyc();
    settle();
    check("rr_final_out_valid", 32'(r_out_valid), 0);
    cyc();

    check("sb_fix_drained", 32'(exp_f.size()), 0);
    check("sb_rr_drained", 32'(exp_r.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
